// File: rtl/cursor_pkg.sv
// Shared widths, cursor geometry and position clamp helper for the cursor overlay.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cursor_pkg;

    localparam int CURSOR_W = 8;
    localparam int CURSOR_H = 11;
    localparam int RGB_W    = 8;
    localparam int POS_W    = 10;

    localparam logic [RGB_W-1:0] CURSOR_COLOR_DEF = 8'hFF;

    // Saturate a requested cursor coordinate to the last visible column/line.
    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] val,
                                                   input logic [POS_W-1:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth register delay line, cleared to zero on reset.
// Latency: DEPTH clocks from d to q.
// Backpressure: none; advances every clock.
module sync_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // Shift the input through DEPTH registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/mouse_cursor_overlay.sv
// Composites an 8x11 ROM-defined mouse cursor over the background VGA pixel stream.
// Latency: 2 clocks from hcount/vcount/rgb_in (and hsync/vsync) to outputs.
// Backpressure: none; pixel-rate stream. Build option CURSOR_XOR_EN draws cursor as inverted background.
module mouse_cursor_overlay
    import cursor_pkg::*;
#(
    parameter int               H_ACTIVE     = 640,
    parameter int               V_ACTIVE     = 480,
    parameter logic [RGB_W-1:0] CURSOR_COLOR = CURSOR_COLOR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] hcount,
    input  logic [POS_W-1:0] vcount,
    input  logic             video_on,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             frame_start,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic [POS_W-1:0] mouse_x,
    input  logic [POS_W-1:0] mouse_y,
    input  logic             pos_valid,
    input  logic             cursor_en,
    output logic [4:0]       line_number,
    input  logic [7:0]       line_code,
    output logic [RGB_W-1:0] rgb_out,
    output logic             hsync_out,
    output logic             vsync_out
);

    localparam int COL_W = $clog2(CURSOR_W);
    localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - 1);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - 1);

    logic [POS_W-1:0] pend_x, pend_y;
    logic [POS_W-1:0] act_x, act_y;

    logic [POS_W-1:0] dx, dy;
    logic             in_box;

    logic             in_box_q;
    logic [COL_W-1:0] col_q;
    logic [RGB_W-1:0] rgb_q;
    logic             video_on_q, hsync_q, vsync_q;

    logic             hit;
    logic [RGB_W-1:0] pix_next;

    // Latch new mouse positions immediately; expose them to the scan only at frame start
    // so the cursor cannot tear. Same-cycle update hands the old pending value to act.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_x <= '0;
            pend_y <= '0;
            act_x  <= '0;
            act_y  <= '0;
        end else begin
            if (pos_valid) begin
                pend_x <= clamp_pos(mouse_x, X_MAX);
                pend_y <= clamp_pos(mouse_y, Y_MAX);
            end
            if (frame_start) begin
                act_x <= pend_x;
                act_y <= pend_y;
            end
        end
    end

    // Offset into the cursor box; negative offsets wrap high and fall outside.
    always_comb begin
        dx     = hcount - act_x;
        dy     = vcount - act_y;
        in_box = (dx < POS_W'(CURSOR_W)) && (dy < POS_W'(CURSOR_H)) && cursor_en;
    end

    // Stage 1: ROM row address, column select and box flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_number <= '0;
            col_q       <= '0;
            in_box_q    <= 1'b0;
        end else begin
            line_number <= in_box ? dy[4:0] : 5'd0;
            col_q       <= dx[COL_W-1:0];
            in_box_q    <= in_box;
        end
    end

    sync_delay #(.WIDTH(3), .DEPTH(1)) u_ctrl_s1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({video_on, hsync_in, vsync_in}),
        .q     ({video_on_q, hsync_q, vsync_q})
    );

    sync_delay #(.WIDTH(RGB_W), .DEPTH(1)) u_rgb_s1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rgb_in),
        .q     (rgb_q)
    );

    sync_delay #(.WIDTH(2), .DEPTH(1)) u_sync_s2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({hsync_q, vsync_q}),
        .q     ({hsync_out, vsync_out})
    );

    // Stage 2 pixel select: blank outside the visible area, cursor over background.
    always_comb begin
        hit = in_box_q & video_on_q & line_code[col_q];
        if (!video_on_q) begin
            pix_next = '0;
        end else if (hit) begin
`ifdef CURSOR_XOR_EN
            pix_next = rgb_q ^ CURSOR_COLOR;
`else
            pix_next = CURSOR_COLOR;
`endif
        end else begin
            pix_next = rgb_q;
        end
    end

    // Stage 2 register: composited pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= pix_next;
        end
    end

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
module tb_mouse_cursor_overlay;

`ifdef CURSOR_XOR_EN
    localparam logic [7:0] HITC = 8'hED;
`else
    localparam logic [7:0] HITC = 8'hFF;
`endif
    localparam logic [7:0] BG = 8'h12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hcount = '0, vcount = '0;
    logic       video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] rgb_in = '0;
    logic [9:0] mouse_x = '0, mouse_y = '0;
    logic       pos_valid = 1'b0, cursor_en = 1'b1;
    logic [4:0] line_number;
    logic [7:0] line_code;
    logic [7:0] rgb_out;
    logic       hsync_out, vsync_out;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    logic [7:0] q_rgb  [$];
    logic [1:0] q_sync [$];

    always #5 clk = ~clk;

    mouse_cursor_overlay dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .video_on    (video_on),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .frame_start (frame_start),
        .rgb_in      (rgb_in),
        .mouse_x     (mouse_x),
        .mouse_y     (mouse_y),
        .pos_valid   (pos_valid),
        .cursor_en   (cursor_en),
        .line_number (line_number),
        .line_code   (line_code),
        .rgb_out     (rgb_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    // Cursor bitmap ROM model: arrow shape, row 0 = 0x01, row 7 = 0xFF.
    function automatic logic [7:0] rom(input logic [4:0] r);
        case (r)
            5'd0:  return 8'h01;
            5'd1:  return 8'h03;
            5'd2:  return 8'h07;
            5'd3:  return 8'h0F;
            5'd4:  return 8'h1F;
            5'd5:  return 8'h3F;
            5'd6:  return 8'h7F;
            5'd7:  return 8'hFF;
            5'd8:  return 8'h1F;
            5'd9:  return 8'h1B;
            5'd10: return 8'h0F;
            default: return 8'h00;
        endcase
    endfunction

    assign line_code = rom(line_number);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one pixel, push its expected output, clock, then compare line_number
    // (1-cycle) and the oldest scoreboard entry (2-cycle).
    task automatic pix(input string tag, input logic [9:0] h, input logic [9:0] v,
                       input logic von, input logic [7:0] rgb,
                       input logic [4:0] exp_ln, input logic [7:0] exp_rgb);
        logic [7:0] e_rgb;
        logic [1:0] e_sync;
        hcount   = h;
        vcount   = v;
        video_on = von;
        rgb_in   = rgb;
        hsync_in = cyc_n[0];
        vsync_in = cyc_n[1];
        cyc_n++;
        q_rgb.push_back(exp_rgb);
        q_sync.push_back({hsync_in, vsync_in});
        @(posedge clk);
        #1;
        pos_valid   = 1'b0;
        frame_start = 1'b0;
        chk({tag, "_ln"}, 32'(line_number), 32'(exp_ln));
        if (q_rgb.size() >= 2) begin
            e_rgb  = q_rgb.pop_front();
            e_sync = q_sync.pop_front();
            chk({tag, "_rgb"}, 32'(rgb_out), 32'(e_rgb));
            chk({tag, "_sync"}, 32'({hsync_out, vsync_out}), 32'(e_sync));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix("idle", 10'd1000, 10'd1000, 1'b0, 8'h00, 5'd0, 8'h00);
    endtask

    task automatic move_to(input logic [9:0] x, input logic [9:0] y);
        mouse_x   = x;
        mouse_y   = y;
        pos_valid = 1'b1;
        idle(1);
        frame_start = 1'b1;
        idle(1);
    endtask

    initial begin
        #2;
        chk("rst_rgb", 32'(rgb_out), 32'h0);
        chk("rst_ln", 32'(line_number), 32'h0);
        chk("rst_sync", 32'({hsync_out, vsync_out}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset position is (0,0): cursor tip at the origin.
        pix("org_hit", 10'd0, 10'd0, 1'b1, BG, 5'd0, HITC);
        pix("org_miss", 10'd1, 10'd0, 1'b1, BG, 5'd0, BG);
        idle(2);

        move_to(10'd100, 10'd50);
        // 1. tip pixel and its right neighbour
        pix("t1_hit", 10'd100, 10'd50, 1'b1, BG, 5'd0, HITC);
        pix("t1_miss", 10'd101, 10'd50, 1'b1, BG, 5'd0, BG);
        // 2. full row 7, bottom row, just below, just right
        pix("t2_row7", 10'd107, 10'd57, 1'b1, BG, 5'd7, HITC);
        pix("t2_row10", 10'd100, 10'd60, 1'b1, BG, 5'd10, HITC);
        pix("t2_dy11", 10'd100, 10'd61, 1'b1, BG, 5'd0, BG);
        pix("t2_dx8", 10'd108, 10'd50, 1'b1, BG, 5'd0, BG);
        pix("t2_bg", 10'd200, 10'd50, 1'b1, 8'hA5, 5'd0, 8'hA5);
        // 3. left wrap, blanking inside the box, cursor disabled
        pix("t3_wrap", 10'd99, 10'd50, 1'b1, BG, 5'd0, BG);
        pix("t3_blank", 10'd107, 10'd57, 1'b0, BG, 5'd7, 8'h00);
        cursor_en = 1'b0;
        pix("t3_dis", 10'd100, 10'd50, 1'b1, BG, 5'd0, BG);
        cursor_en = 1'b1;
        pix("t3_ena", 10'd100, 10'd50, 1'b1, BG, 5'd0, HITC);

        // 4. pending update is invisible until frame_start
        mouse_x = 10'd300; mouse_y = 10'd200; pos_valid = 1'b1;
        pix("t4_old", 10'd100, 10'd50, 1'b1, BG, 5'd0, HITC);
        pix("t4_notyet", 10'd300, 10'd200, 1'b1, BG, 5'd0, BG);
        frame_start = 1'b1;
        idle(1);
        pix("t4_new", 10'd300, 10'd200, 1'b1, BG, 5'd0, HITC);
        pix("t4_gone", 10'd100, 10'd50, 1'b1, BG, 5'd0, BG);
        move_to(10'd700, 10'd500);
        pix("t4_clamp", 10'd639, 10'd479, 1'b1, BG, 5'd0, HITC);
        pix("t4_hblank", 10'd640, 10'd479, 1'b0, BG, 5'd0, 8'h00);
        pix("t4_vblank", 10'd639, 10'd480, 1'b0, BG, 5'd1, 8'h00);

        // 5. simultaneous pos_valid and frame_start: act takes the old pend
        mouse_x = 10'd100; mouse_y = 10'd50; pos_valid = 1'b1; frame_start = 1'b1;
        idle(1);
        pix("t5_stay", 10'd639, 10'd479, 1'b1, BG, 5'd0, HITC);
        pix("t5_notnew", 10'd100, 10'd50, 1'b1, BG, 5'd0, BG);
        frame_start = 1'b1;
        idle(1);
        pix("t5_new", 10'd100, 10'd50, 1'b1, BG, 5'd0, HITC);
        pix("t5_old", 10'd639, 10'd479, 1'b1, BG, 5'd0, BG);
        idle(2);

        // 6. asynchronous reset mid-line
        pix("t6_pre", 10'd107, 10'd57, 1'b1, BG, 5'd7, HITC);
        pix("t6_pre2", 10'd107, 10'd57, 1'b1, BG, 5'd7, HITC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rgb", 32'(rgb_out), 32'h0);
        chk("t6_ln", 32'(line_number), 32'h0);
        chk("t6_sync", 32'({hsync_out, vsync_out}), 32'h0);
        q_rgb.delete();
        q_sync.delete();
        @(negedge clk);
        rst_n = 1'b1;
        // position back at (0,0); first output after release still zero
        pix("t6_rel", 10'd0, 10'd0, 1'b1, BG, 5'd0, HITC);
        chk("t6_rel_rgb", 32'(rgb_out), 32'h0);
        pix("t6_org", 10'd3, 10'd3, 1'b1, BG, 5'd3, HITC);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
